// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared constants and helpers for the registered stream multiplexer
package mux_pkg;

    // Channel selection modes
    localparam int MODE_SEL = 0;    // channel chosen by the external SEL input
    localparam int MODE_RR  = 1;    // channel chosen by round-robin arbitration

    // Width of a channel index; never narrower than one bit
    function automatic int calc_sel_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter starting after a pointer
//
// Ports:
//   i_req   [N_CH-1:0]   request vector, one bit per channel
//   i_ptr   [SEL_W-1:0]  index of the last granted channel
//   o_grant [N_CH-1:0]   one-hot grant (all zero when nothing requests)
//   o_idx   [SEL_W-1:0]  encoded index of the granted channel
//   o_found              high when some channel is granted
module rr_arbiter import mux_pkg::*; #(
    parameter int N_CH  = 4,
    parameter int SEL_W = calc_sel_w(N_CH)
) (
    input  logic [N_CH-1:0]  i_req,
    input  logic [SEL_W-1:0] i_ptr,
    output logic [N_CH-1:0]  o_grant,
    output logic [SEL_W-1:0] o_idx,
    output logic             o_found
);

    logic [SEL_W-1:0] w_ch;

    // Search ptr+1, ptr+2, ... wrapping; the last step revisits ptr itself,
    // so the previously granted channel has the lowest priority.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_found = 1'b0;
        w_ch    = '0;
        for (int k = 1; k <= N_CH; k++) begin
            w_ch = SEL_W'((int'(i_ptr) + k) % N_CH);
            if (!o_found && i_req[w_ch]) begin
                o_found       = 1'b1;
                o_grant[w_ch] = 1'b1;
                o_idx         = w_ch;
            end
        end
    end

endmodule

// File: rtl/stream_mux_reg.sv
// rtl/stream_mux_reg.sv - N-channel registered stream multiplexer with select or round-robin mode
//
// Ports:
//   CLK        rising-edge clock
//   RST        asynchronous active-low reset
//   IN_DATA    flattened channel data, channel i at [i*DATA_W +: DATA_W]
//   IN_VALID   per-channel valid
//   IN_READY   per-channel ready (combinational, at most one bit high)
//   SEL        channel select, MODE_SEL only
//   OUT_DATA   registered output word
//   OUT_VALID  registered output valid
//   OUT_READY  downstream ready
//   OUT_CH     registered index of the channel that supplied OUT_DATA
module stream_mux_reg import mux_pkg::*; #(
    parameter int DATA_W = 8,
    parameter int N_CH   = 4,
    parameter int MODE   = MODE_SEL,
    parameter int SEL_W  = calc_sel_w(N_CH)
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [N_CH*DATA_W-1:0]   IN_DATA,
    input  logic [N_CH-1:0]          IN_VALID,
    output logic [N_CH-1:0]          IN_READY,
    input  logic [SEL_W-1:0]         SEL,
    output logic [DATA_W-1:0]        OUT_DATA,
    output logic                     OUT_VALID,
    input  logic                     OUT_READY,
    output logic [SEL_W-1:0]         OUT_CH
);

    logic [DATA_W-1:0] r_out_data;
    logic              r_out_valid;
    logic [SEL_W-1:0]  r_out_ch;

    logic              w_load;
    logic              w_take;
    logic              w_cand_ok;
    logic [SEL_W-1:0]  w_cand_idx;
    logic [N_CH-1:0]   w_onehot;
    logic [DATA_W-1:0] w_cand_data;

    // The output register may accept a word when empty or when draining this cycle
    assign w_load = !r_out_valid || OUT_READY;
    assign w_take = RST && w_load && w_cand_ok;

    generate
        if (MODE == MODE_RR) begin : g_rr
            logic [SEL_W-1:0] r_ptr;
            logic             w_unused_sel;

            assign w_unused_sel = ^SEL;

            rr_arbiter #(
                .N_CH  (N_CH),
                .SEL_W (SEL_W)
            ) u_arb (
                .i_req   (IN_VALID),
                .i_ptr   (r_ptr),
                .o_grant (w_onehot),
                .o_idx   (w_cand_idx),
                .o_found (w_cand_ok)
            );

            // Reset value N_CH-1 gives channel 0 first priority
            always_ff @(posedge CLK or negedge RST) begin
                if (!RST) begin
                    r_ptr <= SEL_W'(N_CH - 1);
                end else if (w_take) begin
                    r_ptr <= w_cand_idx;
                end
            end
        end else begin : g_sel
            assign w_cand_idx = SEL;
            assign w_onehot   = N_CH'(1) << SEL;

            // An out-of-range select is simply no candidate
            always_comb begin
                w_cand_ok = 1'b0;
                if (int'(SEL) < N_CH) begin
                    w_cand_ok = IN_VALID[SEL];
                end
            end
        end
    endgenerate

    assign IN_READY = w_take ? w_onehot : '0;

    always_comb begin
        w_cand_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (SEL_W'(i) == w_cand_idx) begin
                w_cand_data = IN_DATA[i*DATA_W +: DATA_W];
            end
        end
    end

    // Data and channel hold when nothing is loaded; only valid drops
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_ch    <= '0;
        end else if (w_load) begin
            if (w_cand_ok) begin
                r_out_data  <= w_cand_data;
                r_out_ch    <= w_cand_idx;
                r_out_valid <= 1'b1;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign OUT_DATA  = r_out_data;
    assign OUT_VALID = r_out_valid;
    assign OUT_CH    = r_out_ch;

endmodule

// File: doc/stream_mux_reg.md
Name: stream_mux_reg

Overview:
- Parametrised N-channel registered stream multiplexer.
- It is the next generation of the team's registered 2:1 select mux. It adds:
  - width and channel-count generics
  - per-channel valid/ready handshaking
  - a registered output stage with backpressure
  - a selectable mode: externally selected, or round-robin arbitrated
- Sits between multiple producers (e.g. TX data sources) and a single downstream consumer.

Parameters:
- DATA_W, 8: width of each channel's data word.
- N_CH, 4: number of input channels; legal range 2..16.
- MODE, 0: 0 = external select via SEL; 1 = round-robin arbitration (SEL ignored).
- SEL_W, max(1, $clog2(N_CH)): width of SEL and OUT_CH (derived; do not override).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- IN_DATA  in  N_CH*DATA_W  flattened channel data; channel i occupies bits [i*DATA_W +: DATA_W].
- IN_VALID  in  N_CH  per-channel valid.
- IN_READY  out  N_CH  per-channel ready (combinational).
- SEL  in  SEL_W  channel select, used in MODE 0 only.
- OUT_DATA  out  DATA_W  registered output data.
- OUT_VALID  out  1  registered output valid.
- OUT_READY  in  1  downstream ready.
- OUT_CH  out  SEL_W  registered index of the channel that supplied OUT_DATA.

Behaviour:
- Reset (RST low, asynchronous):
  - OUT_DATA = 0, OUT_VALID = 0, OUT_CH = 0.
  - Round-robin pointer = N_CH-1, so channel 0 has first priority.
  - All IN_READY = 0 while RST is low.
- Transfer rule: a transfer occurs on a channel or the output when valid and ready are both high at a rising CLK edge.
- Load enable: LOAD = !OUT_VALID || OUT_READY. The output register accepts a new word only when LOAD is high.
- Channel choice, cycle by cycle:
  - MODE 0: candidate c = SEL. If SEL >= N_CH, there is no candidate.
  - MODE 1: c = the first channel with IN_VALID high, searching ptr+1, ptr+2, ... with wrap modulo N_CH. If no channel is valid, there is no candidate.
- Ready and load:
  - IN_READY[c] = LOAD && IN_VALID[c]. All other IN_READY bits are 0.
  - At most one IN_READY bit is high in any cycle.
- On a transfer from channel c:
  - OUT_DATA <= IN_DATA[c].
  - OUT_CH <= c.
  - OUT_VALID <= 1.
  - In MODE 1, ptr <= c.
- If LOAD is high and there is no candidate or the candidate is not valid: OUT_VALID <= 0. OUT_DATA and OUT_CH hold their values.
- If LOAD is low (OUT_VALID high and OUT_READY low):
  - OUT_DATA, OUT_CH and OUT_VALID are held stable.
  - All IN_READY = 0.
  - ptr is unchanged.
- Timing:
  - Latency is 1 cycle from an input transfer to OUT_VALID.
  - Throughput is 1 word per cycle with OUT_READY held high.
- Round-robin fairness: with all channels continuously valid, grants rotate 0, 1, ..., N_CH-1, 0, ... A channel waits at most N_CH-1 grants.
- SEL may change every cycle and is sampled only in cycles where LOAD is high.
- Simultaneous output drain and input transfer in the same cycle is a full-throughput reload, with no bubble.
- Reset asserted mid-operation clears the output register and the pointer immediately. Any pending output word is lost; no partial state survives.
- No combinational path from IN_DATA to OUT_DATA.
- Combinational paths exist from OUT_READY, IN_VALID and SEL to IN_READY. These are the only combinational paths.

Decomposition:
- Shared package (mux_pkg):
  - constants MODE_SEL = 0 and MODE_RR = 1
  - a function computing SEL_W from N_CH
- One sub-module, rr_arbiter:
  - inputs: request vector and pointer
  - outputs: one-hot grant and encoded index
  - purely combinational
  - instantiated only when MODE = 1

Test Plan:
- Reset and basic transfer: hold RST low for 3 cycles, then release. Set MODE 0, N_CH = 4, SEL = 2, IN_VALID = 0100, channel 2 data = 8'hA5, OUT_READY = 1. Required: OUT_DATA = 0 and OUT_VALID = 0 during reset; one cycle later OUT_DATA = A5, OUT_CH = 2, OUT_VALID = 1.
- Backpressure: with OUT_VALID = 1 holding 8'h11, drive OUT_READY = 0 for 5 cycles while channel 2 presents 8'h22. Required: OUT_DATA stays 11 and IN_READY = 0000 throughout. After OUT_READY rises, 22 appears on the next cycle with no bubble.
- Round-robin fairness: MODE 1, all four IN_VALID high continuously, OUT_READY = 1. Required: OUT_CH sequence is 0, 1, 2, 3, 0, 1 over 6 consecutive cycles.
- Round-robin skip: MODE 1, IN_VALID = 1010, with ptr last granting channel 1. Required: channel 3 is granted next, then channel 1.
- Out-of-range select: N_CH = 3, MODE 0, SEL = 3, all channels valid. Required: IN_READY = 000 and OUT_VALID falls to 0 after the current word drains.
- Reset mid-stream: assert RST asynchronously mid-cycle while OUT_VALID = 1 and OUT_DATA = 8'h5A. Required: OUT_DATA = 0 and OUT_VALID = 0 immediately; after release in MODE 1, the first grant goes to the lowest-index valid channel.
